reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the 32-bit MIPS datapath.
- Replaces the fixed 32x32, 2-read/1-write file: configurable width, depth and read-port count, plus a second write port (writeback plus load/HI-LO).
- Adds optional hardwired zero register, asynchronous reset and a sequenced clear engine that sweeps the array to zero, one entry per cycle.

Parameters:
- DW, 32, data width in bits
- DEPTH, 32, number of registers (power of 2, >=2)
- AW, 5, address width, must equal log2(DEPTH)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NUM_RD*DW  read data; port k uses bits [k*DW +: DW]
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  AW  write port 0 address
- wr_data0  in  DW  write port 0 data
- wr_en1  in  1  write port 1 enable
- wr_addr1  in  AW  write port 1 address
- wr_data1  in  DW  write port 1 data
- clr_req  in  1  request a full-array clear sweep
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the last entry is cleared

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers = 0
  - FSM = IDLE, sweep counter = 0
  - clr_busy = 0, clr_done = 0
  - rd_data = 0 (all entries zero)
- Reads: combinational. rd_data[k] = reg[rd_addr[k]] with no latency.
- Zero register: with ZERO_REG=1, reading address 0 returns 0 and writes to address 0 are discarded.
- Writes: committed on the rising clk edge when wr_en is high, the FSM is IDLE and clr_req is not being accepted that cycle. Written data is visible on reads in the cycle after the edge.
- Write collision: both ports enabled to the same address → port 1 wins, port 0 is discarded.
- Different addresses on the two ports are both written in the same cycle.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when clr_req=1. Writes in the accepting cycle are dropped. Counter is loaded with 0.
  - In CLEAR, each cycle sets reg[counter]=0 and increments counter. clr_busy=1.
  - CLEAR → IDLE on the cycle that clears entry DEPTH-1. clr_done pulses high for the next cycle only; clr_busy falls on that same cycle.
  - Sweep length: exactly DEPTH cycles of clr_busy=1.
- During CLEAR:
  - writes on either port are ignored (silently dropped; the pipeline stalls on clr_busy)
  - clr_req is ignored
  - reads return live contents: entries already swept read 0, unswept entries keep their old values
- Counter wrap: the counter is AW bits wide and wraps to 0 on exit; no stale state carries over.
- Reset mid-sweep: immediately to IDLE with the array all zero; no clr_done pulse.
- clr_req held high continuously: a new sweep starts on the cycle after clr_done (back-to-back sweeps).

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN
- Defined: write-to-read bypass.
  - If a read address matches an enabled, accepted write address in the same cycle, rd_data returns the write data combinationally.
  - Port 1 data takes priority on a dual match.
  - No bypass for address 0 when ZERO_REG=1.
  - No bypass while clr_busy=1 or in the clr_req accept cycle.
- Undefined: reads return pre-edge contents, with the write visible one cycle later.

Test Plan:
- Reset then read: rst_n=0 → all rd_data=0. Write 0x0000FFFF to r10 via port 0, then read r10 on port 0 → 0x0000FFFF. Read r14 on port 1 the same cycle → 0.
- Dual write collision: wr0 r31=0xAAAAAAAA and wr1 r31=0x5555AAAA in the same cycle → r31 reads 0x5555AAAA. Separately, wr0 r3=1 and wr1 r4=2 → both stored.
- Zero register: write 0xDEADBEEF to r0 → r0 reads 0. With ZERO_REG=0 the same write → r0 reads 0xDEADBEEF.
- Clear sweep:
  - Setup: fill r0..r31 with 0x100+i.
  - Pulse clr_req → clr_busy high for exactly 32 cycles, then clr_done for 1 cycle.
  - Mid-sweep, after 10 cycles: r9 reads 0 and r20 reads 0x114.
  - A write issued mid-sweep is dropped: the target reads 0 after completion.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 5 → clr_busy=0 immediately, no clr_done, all regs read 0.
- Bypass, only with REG_FILE_MP_BYPASS_EN: wr1 r14=0x0000FF00 while rd_addr port 0 = r14 → same-cycle rd_data = 0x0000FF00. Without the macro → old value that cycle, 0x0000FF00 the next cycle.

Source files
------------

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- parametrised multi-port register file for the MIPS datapath
//
// Two write ports (writeback plus load/HI-LO), NUM_RD combinational read
// ports, an optional hardwired zero register, and a clear engine that sweeps
// the whole array to zero one entry per clock.
//
// Ports:
//   clk       rising-edge system clock
//   rst_n     asynchronous active-low reset (array, FSM and counter to zero)
//   rd_addr   NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rd_data   NUM_RD packed read data, port k at [k*DW +: DW]
//   wr_en0/wr_addr0/wr_data0   write port 0
//   wr_en1/wr_addr1/wr_data1   write port 1 (wins on an address collision)
//   clr_req   start a clear sweep (accepted only while idle)
//   clr_busy  high while the sweep is running
//   clr_done  one-cycle pulse after the last entry has been cleared
//
// Build option:
//   REG_FILE_MP_BYPASS_EN  when defined, a read that hits an accepted write
//                          in the same cycle returns the write data
//                          combinationally instead of the pre-edge contents.
// ---------------------------------------------------------------------------
module reg_file_mp #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   input  logic                 wr_en0,
   input  logic [AW-1:0]        wr_addr0,
   input  logic [DW-1:0]        wr_data0,
   input  logic                 wr_en1,
   input  logic [AW-1:0]        wr_addr1,
   input  logic [DW-1:0]        wr_data1,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]    state;
   logic [AW-1:0] clrCount;
   logic [DW-1:0] mem [DEPTH];

   logic          writeOk;
   logic          acceptClr;
   logic          lastEntry;
   logic          we0;
   logic          we1;

   // Writes only land while idle and not on the cycle a clear is being
   // accepted; register 0 swallows writes when it is hardwired to zero.
   always_comb begin
      writeOk   = (state == IDLE) && !clr_req;
      acceptClr = (state == IDLE) && clr_req;
      lastEntry = (clrCount == AW'(DEPTH - 1));
      we0       = wr_en0 && writeOk && !((ZERO_REG != 0) && (wr_addr0 == '0));
      we1       = wr_en1 && writeOk && !((ZERO_REG != 0) && (wr_addr1 == '0));
   end

   assign clr_busy = (state == CLEAR);

   // Clear engine control: IDLE waits for clr_req, CLEAR walks the counter
   // across every entry and returns to IDLE after the last one, raising
   // clr_done for exactly the following cycle. The counter wraps back to
   // zero on exit so nothing stale is left for the next sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clrCount <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (acceptClr) begin
                  state    <= CLEAR;
                  clrCount <= '0;
               end
            end
            CLEAR: begin
               clrCount <= clrCount + AW'(1);
               if (lastEntry) begin
                  state    <= IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               clrCount <= '0;
            end
         endcase
      end
   end

   // Storage array. During a sweep the entry under the counter is zeroed and
   // both write ports are ignored. Otherwise port 1 is assigned after port 0
   // so that it takes priority when both target the same address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == CLEAR) begin
         mem[clrCount] <= '0;
      end else begin
         if (we0) begin
            mem[wr_addr0] <= wr_data0;
         end
         if (we1) begin
            mem[wr_addr1] <= wr_data1;
         end
      end
   end

   // Combinational read ports. With the bypass build an accepted write to
   // the same address is forwarded (port 1 checked last so it wins). The
   // zero-register override is applied last so address 0 never forwards.
   always_comb begin
      logic [AW-1:0] rAddr;
      logic [DW-1:0] rVal;
      rAddr   = '0;
      rVal    = '0;
      rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rAddr = rd_addr[k*AW +: AW];
         rVal  = mem[rAddr];
`ifdef REG_FILE_MP_BYPASS_EN
         if (writeOk) begin
            if (wr_en0 && (wr_addr0 == rAddr)) begin
               rVal = wr_data0;
            end
            if (wr_en1 && (wr_addr1 == rAddr)) begin
               rVal = wr_data1;
            end
         end
`else
         // Without the bypass, reads always see the pre-edge contents.
`endif
         if ((ZERO_REG != 0) && (rAddr == '0)) begin
            rVal = '0;
         end
         rd_data[k*DW +: DW] = rVal;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp
//
// Two instances share every input: dutZ has the hardwired zero register,
// dutN does not. A behavioural model of the register contents and sweep
// progress is checked against both instances on every falling clock edge,
// and directed sequences add hand-computed literal expectations.
// Honours REG_FILE_MP_BYPASS_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rdDataZ;
   logic [63:0] rdDataN;
   logic        wr_en0 = 1'b0;
   logic [4:0]  wr_addr0 = '0;
   logic [31:0] wr_data0 = '0;
   logic        wr_en1 = 1'b0;
   logic [4:0]  wr_addr1 = '0;
   logic [31:0] wr_data1 = '0;
   logic        clr_req = 1'b0;
   logic        clrBusyZ, clrDoneZ, clrBusyN, clrDoneN;

   int vectors = 0;
   int miscompares = 0;

   reg_file_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(1)) dutZ (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdDataZ),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .clr_req(clr_req), .clr_busy(clrBusyZ), .clr_done(clrDoneZ)
   );

   reg_file_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(0)) dutN (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdDataN),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .clr_req(clr_req), .clr_busy(clrBusyN), .clr_done(clrDoneN)
   );

   // Free-running clock, 10 time units per period.
   initial forever #5 clk = ~clk;

   // Model state: register contents for each instance, whether a sweep is
   // running, which entry it clears next, and the done pulse.
   logic [31:0] memZ [32];
   logic [31:0] memN [32];
   logic        mSweep;
   int          mIdx;
   logic        mDone;

   // Model update: a sweep zeroes one entry per clock for 32 clocks, then
   // signals done for one clock. Writes land only when idle and no clear is
   // requested; port 1 is applied last so it wins a collision.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            memZ[i] <= '0;
            memN[i] <= '0;
         end
         mSweep <= 1'b0;
         mIdx   <= 0;
         mDone  <= 1'b0;
      end else begin
         mDone <= 1'b0;
         if (mSweep) begin
            memZ[mIdx] <= '0;
            memN[mIdx] <= '0;
            if (mIdx == 31) begin
               mSweep <= 1'b0;
               mDone  <= 1'b1;
               mIdx   <= 0;
            end else begin
               mIdx <= mIdx + 1;
            end
         end else if (clr_req) begin
            mSweep <= 1'b1;
            mIdx   <= 0;
         end else begin
            if (wr_en0) begin
               memN[wr_addr0] <= wr_data0;
               if (wr_addr0 != 5'd0) memZ[wr_addr0] <= wr_data0;
            end
            if (wr_en1) begin
               memN[wr_addr1] <= wr_data1;
               if (wr_addr1 != 5'd0) memZ[wr_addr1] <= wr_data1;
            end
         end
      end
   end

   // Expected read value for one address on one instance.
   function automatic logic [31:0] expRead(input bit zero, input logic [4:0] a);
      logic [31:0] v;
      v = zero ? memZ[a] : memN[a];
`ifdef REG_FILE_MP_BYPASS_EN
      if (!mSweep && !clr_req) begin
         if (wr_en0 && wr_addr0 == a) v = wr_data0;
         if (wr_en1 && wr_addr1 == a) v = wr_data1;
      end
`endif
      if (zero && a == 5'd0) v = '0;
      return v;
   endfunction

   // Single comparison point used by every check in the bench.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle compare of every output of both instances against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("cycZ_rd%0d", k), rdDataZ[k*32 +: 32], expRead(1'b1, rd_addr[k*5 +: 5]));
         checkOutput($sformatf("cycN_rd%0d", k), rdDataN[k*32 +: 32], expRead(1'b0, rd_addr[k*5 +: 5]));
      end
      checkOutput("cycZ_busy", {31'd0, clrBusyZ}, {31'd0, mSweep});
      checkOutput("cycZ_done", {31'd0, clrDoneZ}, {31'd0, mDone});
      checkOutput("cycN_busy", {31'd0, clrBusyN}, {31'd0, mSweep});
      checkOutput("cycN_done", {31'd0, clrDoneN}, {31'd0, mDone});
   end

   // Drive one set of write/clear inputs (held until changed).
   task automatic applyStimulus(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic clr);
      wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
      wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
      clr_req = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence.
   initial begin
      int busyCount;
      int guard;
      int doneSeen;
      bit stop;

      // Reset then read.
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rd_addr = {5'd14, 5'd10};
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rd0", rdDataZ[31:0], 32'h0);
      checkOutput("reset_rd1", rdDataZ[63:32], 32'h0);
      #2 rst_n = 1'b1;
      applyStimulus(1, 5'd10, 32'h0000FFFF, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("wr_r10", rdDataZ[31:0], 32'h0000FFFF);
      checkOutput("rd_r14", rdDataZ[63:32], 32'h0);

      // Dual write collision, then two distinct addresses.
      tick();
      applyStimulus(1, 5'd31, 32'hAAAAAAAA, 1, 5'd31, 32'h5555AAAA, 0);
      tick();
      applyStimulus(1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rd_addr = {5'd3, 5'd31};
      @(negedge clk);
      checkOutput("collide_r31", rdDataZ[31:0], 32'h5555AAAA);
      checkOutput("dual_r3", rdDataZ[63:32], 32'd1);
      #1 rd_addr = {5'd3, 5'd4};
      #1 checkOutput("dual_r4", rdDataZ[31:0], 32'd2);

      // Zero register on dutZ, ordinary register on dutN.
      tick();
      applyStimulus(1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rd_addr = {5'd0, 5'd0};
      @(negedge clk);
      checkOutput("zero_r0_z", rdDataZ[31:0], 32'h0);
      checkOutput("zero_r0_n", rdDataN[31:0], 32'hDEADBEEF);

      // Fill r0..r31 with 0x100+i, two entries per cycle.
      tick();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 5'(2*i), 32'(256 + 2*i), 1, 5'(2*i + 1), 32'(256 + 2*i + 1), 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rd_addr = {5'd20, 5'd9};

      // Clear sweep with a dropped mid-sweep write to an already-swept entry.
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      busyCount = 0;
      guard = 0;
      stop = 0;
      while (!stop && guard < 100) begin
         @(negedge clk);
         guard++;
         if (!clrBusyZ) begin
            stop = 1;
         end else begin
            busyCount++;
            if (busyCount == 11) begin
               checkOutput("mid_r9", rdDataZ[31:0], 32'h0);
               checkOutput("mid_r20", rdDataZ[63:32], 32'h114);
               applyStimulus(1, 5'd3, 32'h00000BAD, 0, 0, 0, 0);
            end
            if (busyCount == 12) applyStimulus(0, 0, 0, 0, 0, 0, 0);
         end
      end
      checkOutput("sweep_len", 32'(busyCount), 32'd32);
      checkOutput("sweep_done", {31'd0, clrDoneZ}, 32'd1);
      @(negedge clk);
      checkOutput("done_pulse_end", {31'd0, clrDoneZ}, 32'd0);
      #1 rd_addr = {5'd20, 5'd3};
      #1 checkOutput("dropped_wr_r3", rdDataZ[31:0], 32'h0);
      checkOutput("swept_r20", rdDataZ[63:32], 32'h0);

      // Reset in the middle of a sweep.
      tick();
      rd_addr = {5'd5, 5'd5};
      applyStimulus(1, 5'd5, 32'h55, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      busyCount = 0;
      guard = 0;
      while (busyCount < 5 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (clrBusyZ) busyCount++;
      end
      checkOutput("pre_rst_r5", rdDataZ[31:0], 32'h55);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_busy", {31'd0, clrBusyZ}, 32'd0);
      checkOutput("rst_done", {31'd0, clrDoneZ}, 32'd0);
      checkOutput("rst_r5", rdDataZ[31:0], 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (clrDoneZ) doneSeen++;
      end
      checkOutput("rst_no_done", 32'(doneSeen), 32'd0);

      // Back-to-back sweeps with clr_req held high.
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      guard = 0;
      stop = 0;
      while (!stop && guard < 60) begin
         @(negedge clk);
         guard++;
         if (clrDoneZ) stop = 1;
      end
      checkOutput("b2b_first_done", {31'd0, clrDoneZ}, 32'd1);
      @(negedge clk);
      checkOutput("b2b_restart", {31'd0, clrBusyZ}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      guard = 0;
      stop = 0;
      while (!stop && guard < 60) begin
         @(negedge clk);
         guard++;
         if (clrDoneZ) stop = 1;
      end
      checkOutput("b2b_second_done", {31'd0, clrDoneZ}, 32'd1);

      // Write-to-read forwarding (or its absence).
      tick();
      applyStimulus(1, 5'd14, 32'h00001234, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 5'd14, 32'h0000FF00, 0);
      rd_addr = {5'd0, 5'd14};
      @(negedge clk);
`ifdef REG_FILE_MP_BYPASS_EN
      checkOutput("bypass_same", rdDataZ[31:0], 32'h0000FF00);
`else
      checkOutput("bypass_same", rdDataZ[31:0], 32'h00001234);
`endif
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("bypass_next", rdDataZ[31:0], 32'h0000FF00);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
